// File: rtl/interval_timer_arbiter_if.sv
// Requester/counter-side signal bundle for interval_timer_arbiter.
// slave = arbiter view, master = environment (requesters plus shared counter).
interface interval_timer_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] req_delay;
  logic [N_REQ-1:0]       grant;
  logic [N_REQ-1:0]       done;
  logic                   busy;
  logic                   cnt_load;
  logic [WIDTH-1:0]       cnt_data;
  logic [WIDTH-1:0]       cnt_value;

  modport slave (
    input  req, req_delay, cnt_value,
    output grant, done, busy, cnt_load, cnt_data
  );

  modport master (
    output req, req_delay, cnt_value,
    input  grant, done, busy, cnt_load, cnt_data
  );
endinterface

// File: rtl/interval_timer_arbiter.sv
// Round-robin owner of a shared up-counter; req->done latency is D+3 cycles, outputs registered.
// No backpressure: a requester holds req until its done pulse, or drops it to abort.
module interval_timer_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  interval_timer_arbiter_if.slave  bus
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  logic [1:0]       state, state_nxt;
  logic [IW-1:0]    ptr, ptr_nxt;
  logic [IW-1:0]    owner, owner_nxt;
  logic [WIDTH-1:0] dly, dly_nxt;

  logic [N_REQ-1:0] grant_q, done_q;
  logic             busy_q, cnt_load_q;
  logic [WIDTH-1:0] cnt_data_q;

  // Round-robin search: rotate req so bit 0 is the requester at ptr.
  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [IW:0]        win_off;
  logic [IW:0]        win_sum;
  logic [IW-1:0]      win;
  logic               win_vld;

  always_comb begin
    req_dbl = {bus.req, bus.req};
    req_rot = req_dbl[ptr +: N_REQ];
    win_vld = |req_rot;
    win_off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) win_off = (IW+1)'(k);
    end
    win_sum = {1'b0, ptr} + win_off;
    if (win_sum >= (IW+1)'(N_REQ))
      win = IW'(win_sum - (IW+1)'(N_REQ));
    else
      win = IW'(win_sum);
  end

  logic owner_req;
  assign owner_req = bus.req[owner];

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    dly_nxt   = dly;
    ptr_nxt   = ptr;
    case (state)
      ST_IDLE: begin
        if (win_vld) begin
          owner_nxt = win;
          dly_nxt   = bus.req_delay[int'(win)*WIDTH +: WIDTH];
          ptr_nxt   = (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_nxt = owner_req ? ST_RUN : ST_IDLE;
      end
      ST_RUN: begin
        // Abort takes precedence over a coincident terminal count.
        if (!owner_req)
          state_nxt = ST_IDLE;
        else if (bus.cnt_value == {WIDTH{1'b1}})
          state_nxt = ST_DONE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      owner      <= '0;
      dly        <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
      cnt_load_q <= 1'b0;
      cnt_data_q <= '0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      owner      <= owner_nxt;
      dly        <= dly_nxt;
      grant_q    <= (state_nxt == ST_LOAD || state_nxt == ST_RUN) ? (ONE << owner_nxt) : '0;
      done_q     <= (state_nxt == ST_DONE) ? (ONE << owner_nxt) : '0;
      busy_q     <= (state_nxt != ST_IDLE);
      cnt_load_q <= (state_nxt == ST_LOAD);
      cnt_data_q <= (state_nxt == ST_LOAD) ? ~dly_nxt : '0;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
  assign bus.cnt_load = cnt_load_q;
  assign bus.cnt_data = cnt_data_q;

  a_grant_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
  a_done_onehot0  : assert property (@(posedge clk) disable iff (rst) $onehot0(done_q));
  a_load_busy     : assert property (@(posedge clk) disable iff (rst) cnt_load_q |-> busy_q);

endmodule

// File: tb/tb_interval_timer_arbiter.sv
// Scoreboarded bench: expected loads/done pulses queued at stimulus time, popped on DUT output.
module tb_interval_timer_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  typedef struct {
    int         cyc;
    int         idx;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errs = 0;
  int   grant_viol = 0;
  exp_t load_q[$];
  exp_t done_q[$];
  exp_t mon_e;
  logic [W-1:0] cnt;

  always #5 clk = ~clk;

  interval_timer_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();
  interval_timer_arbiter #(.N_REQ(N), .WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Shared loadable up-counter beside the arbiter.
  always @(posedge clk) begin
    if (rst)               cnt <= '0;
    else if (bus.cnt_load) cnt <= bus.cnt_data;
    else                   cnt <= cnt + 1'b1;
  end
  assign bus.cnt_value = cnt;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_load(input int c, input int i, input logic [7:0] d);
    exp_t e;
    e.cyc = c; e.idx = i; e.data = d;
    load_q.push_back(e);
  endtask

  task automatic push_done(input int c, input int i);
    exp_t e;
    e.cyc = c; e.idx = i; e.data = 8'h00;
    done_q.push_back(e);
  endtask

  task automatic at_cycle(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if ($countones(bus.grant) > 1) grant_viol++;
      if (bus.cnt_load) begin
        if (load_q.size() == 0) chk("unexpected_load", 32'(bus.cnt_data), 32'hFFFF_FFFF);
        else begin
          mon_e = load_q.pop_front();
          chk("load_cycle", cyc, mon_e.cyc);
          chk("load_data", 32'(bus.cnt_data), 32'(mon_e.data));
          chk("load_grant", 32'(bus.grant), 32'(1) << mon_e.idx);
        end
      end
      if (|bus.done) begin
        if (done_q.size() == 0) chk("unexpected_done", 32'(bus.done), 0);
        else begin
          mon_e = done_q.pop_front();
          chk("done_cycle", cyc, mon_e.cyc);
          chk("done_vec", 32'(bus.done), 32'(1) << mon_e.idx);
          chk("done_grant_clear", 32'(bus.grant), 0);
        end
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_grant"}, 32'(bus.grant), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_load"}, 32'(bus.cnt_load), 0);
    chk({tag, "_data"}, 32'(bus.cnt_data), 0);
  endtask

  // One requester alone; it drops req during its DONE cycle.
  task automatic single(input int idx, input logic [7:0] d, input logic [7:0] exp_data, input int exp_lat);
    int c0;
    bus.req_delay[idx*W +: W] = d;
    bus.req = 4'b0001 << idx;
    c0 = cyc;
    push_load(c0 + 1, idx, exp_data);
    push_done(c0 + exp_lat, idx);
    at_cycle(c0 + exp_lat);
    bus.req = '0;
    at_cycle(c0 + exp_lat + 2);
  endtask

  initial begin
    int c0;
    rst = 1'b1;
    bus.req = '0;
    bus.req_delay = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    at_cycle(cyc + 2);

    // D = 5 on requester 0.
    bus.req_delay[0 +: W] = 8'd5;
    bus.req = 4'b0001;
    c0 = cyc;
    push_load(c0 + 1, 0, 8'hFA);
    push_done(c0 + 8, 0);
    at_cycle(c0 + 2);
    chk("run_busy", 32'(bus.busy), 1);
    chk("run_no_load", 32'(bus.cnt_load), 0);
    chk("run_grant", 32'(bus.grant), 32'h1);
    at_cycle(c0 + 8);
    bus.req = '0;
    at_cycle(c0 + 9);
    chk("idle_after_done_busy", 32'(bus.busy), 0);
    at_cycle(c0 + 11);

    // Abort: req[1] dropped on its 3rd RUN cycle, req[3] pending (ptr = 1 here).
    bus.req_delay[1*W +: W] = 8'd10;
    bus.req_delay[3*W +: W] = 8'd1;
    bus.req = 4'b1010;
    c0 = cyc;
    push_load(c0 + 1, 1, 8'hF5);
    push_load(c0 + 6, 3, 8'hFE);
    push_done(c0 + 9, 3);
    at_cycle(c0 + 4);
    bus.req[1] = 1'b0;
    at_cycle(c0 + 5);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_grant", 32'(bus.grant), 0);
    at_cycle(c0 + 9);
    bus.req = '0;
    at_cycle(c0 + 11);

    // All four held with D = 2: order 0,1,2,3,0 at a 6-cycle period.
    bus.req_delay = {4{8'd2}};
    bus.req = 4'hF;
    c0 = cyc;
    for (int k = 0; k < 5; k++) begin
      push_load(c0 + 6*k + 1, k % 4, 8'hFD);
      push_done(c0 + 6*k + 5, k % 4);
    end
    at_cycle(c0 + 29);
    bus.req = '0;
    at_cycle(c0 + 31);

    // Width extremes on requester 2.
    single(2, 8'h00, 8'hFF, 3);
    single(2, 8'hFF, 8'h00, 258);

    // req_delay[0] changed mid-RUN must not move the done time.
    bus.req_delay[0 +: W] = 8'd20;
    bus.req = 4'b0001;
    c0 = cyc;
    push_load(c0 + 1, 0, 8'hEB);
    push_done(c0 + 23, 0);
    at_cycle(c0 + 5);
    bus.req_delay[0 +: W] = 8'd3;
    at_cycle(c0 + 23);
    bus.req = '0;
    at_cycle(c0 + 25);

    // Reset during RUN; ptr is 1 beforehand, so a surviving ptr would pick 2 after reset.
    bus.req_delay[1*W +: W] = 8'd10;
    bus.req_delay[2*W +: W] = 8'd3;
    bus.req = 4'b0110;
    c0 = cyc;
    push_load(c0 + 1, 1, 8'hF5);
    at_cycle(c0 + 10);
    chk("count_before_rst", 32'(cnt), 32'hFD);
    rst = 1'b1;
    at_cycle(c0 + 11);
    check_idle_outputs("mid_run_rst");
    rst = 1'b0;
    push_load(c0 + 12, 1, 8'hF5);
    push_done(c0 + 24, 1);
    push_load(c0 + 26, 2, 8'hFC);
    push_done(c0 + 31, 2);
    at_cycle(c0 + 24);
    bus.req[1] = 1'b0;
    at_cycle(c0 + 31);
    bus.req = '0;
    at_cycle(c0 + 34);

    chk("loads_outstanding", load_q.size(), 0);
    chk("dones_outstanding", done_q.size(), 0);
    chk("grant_onehot_violations", grant_viol, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
